csi2tx_pixel_capture: RTL and testbench
=======================================

# csi2tx_pixel_capture

Front-end capture stage of the CSI-2 TX pixel-to-byte path. It registers the sensor pixel bus and produces the timing companions the pixel-to-byte converters consume:
- a one-cycle-delayed copy of the pixel data;
- a 4-bit wrapping pixel counter;
- a one-cycle falling-edge pulse of sensor valid;
- the YUV420 10-bit conversion enable and the odd/even line qualifier.

It sits between the sensor pixel interface and every `csi2tx_*_p2b` converter.

## Interface
Parameters:
- `YUV420_10B_DT`, default 6'h19: data type that enables YUV420 10-bit conversion.
- `LINE_CNT_W`, default 16: width of the per-line pixel counter.

Ports:
- `clk`  in  1  pixel-domain clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `sensor_frame_start`  in  1  one-cycle pulse before the first line of a frame.
- `sensor_pixel_vld`  in  1  sensor pixel valid; high for a whole line, low between lines.
- `sensor_pixel_data`  in  32  sensor pixel word; 10-bit components at [29:20], [19:10], [9:0].
- `sensor_data_type`  in  6  CSI-2 data type; sampled at line start.
- `cfg_line_length`  in  LINE_CNT_W  expected pixels per line; used only with the macro.
- `pixel_data`  out  32  registered sensor data.
- `pixel_data_d1`  out  32  `pixel_data` delayed one more cycle.
- `pixel_data_vld`  out  1  registered `sensor_pixel_vld`.
- `pixel_cnt`  out  4  index of the current pixel in the line, mod 16.
- `sensor_pixel_vld_falling_edge`  out  1  one-cycle end-of-line pulse.
- `yuv420_10b_convrn_enable`  out  1  current line is YUV420 10-bit.
- `yuv420_10b_odd_even_convrn_enable`  out  1  0 = odd line (Y only), 1 = even line (YUV).
- `line_length_err`  out  1  sticky length mismatch flag; present only with the macro.

## Operation
- **Reset:** every output is 0. The internal line counter and the stored data type are 0.
- **Data path:**
  - `pixel_data` loads `sensor_pixel_data` every cycle.
  - `pixel_data_d1` loads `pixel_data` every cycle.
  - Neither is gated by valid.
- **Pixel valid:** `pixel_data_vld` follows `sensor_pixel_vld` with 1 cycle of delay.
- **`pixel_cnt`:**
  - While `pixel_data_vld` = 1, `pixel_cnt` increments every cycle. The first valid pixel of a line shows 0, and the count wraps 15 -> 0.
  - On the falling-edge cycle the value holds.
  - It clears to 0 in the cycle after the falling-edge pulse.
- **Falling edge:** `sensor_pixel_vld_falling_edge` = 1 for exactly the first cycle in which `pixel_data_vld` = 0 after being 1.
- **Line start:** defined as the first cycle with `pixel_data_vld` = 1 after it was 0.
  - At line start, `sensor_data_type` (registered alongside the data) is latched.
  - `yuv420_10b_convrn_enable` = (latched type == `YUV420_10B_DT`). It is held constant for the whole line, including the falling-edge cycle.
- **Odd/even:**
  - `sensor_frame_start` forces `yuv420_10b_odd_even_convrn_enable` to 0.
  - The flag toggles in the cycle after each falling-edge pulse, but only while `yuv420_10b_convrn_enable` = 1.
  - The first line of every frame is therefore odd.
- **Frame start during an active line:** odd/even clears immediately. `pixel_cnt` and the line continue unchanged.
- **Back-to-back lines:** if valid drops for exactly 1 cycle, the falling-edge pulse and the `pixel_cnt` clear both still occur. The new line's first pixel shows `pixel_cnt` = 0.
- **Reset mid-line:** all state returns to reset values immediately. The next valid pixel is treated as a line start.

## Timing
- Latency, `sensor_*` -> `pixel_data`, `pixel_data_vld`, `pixel_cnt`: 1 cycle.
- Latency to `pixel_data_d1`: 2 cycles.
- Falling-edge pulse: 1 cycle after the last valid pixel appears on `pixel_data`.
- Enable outputs are stable from the first `pixel_data_vld` of a line through its falling-edge cycle.
- No back-pressure: the downstream stage must accept one pixel per cycle.

## Configuration
- Macro: `CSI2TX_LINE_LEN_CHECK_EN`.
- **Defined:**
  - A `LINE_CNT_W`-bit line counter counts `pixel_data_vld` cycles and saturates at all-ones.
  - On the falling-edge pulse, if count != `cfg_line_length`, `line_length_err` sets.
  - `line_length_err` is sticky and is cleared only by `rst_n` or `sensor_frame_start`.
- **Undefined:** the counter and the port are absent. No other behaviour changes.

## Structure
- Shared package/defines (`csi2tx_defines.v`) holds:
  - the data-type constants, including `YUV420_10B_DT`;
  - the pixel-bus field positions.
- One sub-module, `csi2tx_line_edge_det`: registered valid, rise and fall pulses. It is reused by the other capture variants.

## Test plan
- **Reset:** `rst_n` low with random inputs -> all outputs 0. Release, then 1 idle cycle -> outputs still 0.
- **20-pixel RAW line** (type 6'h2B):
  - `pixel_cnt` runs 0..15, 0..3;
  - falling-edge pulse 1 cycle after the last `pixel_data_vld` while `pixel_cnt` = 3;
  - `pixel_cnt` = 0 on the next cycle;
  - `yuv420_10b_convrn_enable` = 0 throughout.
- **YUV420 10-bit frame of 3 lines** (type 6'h19) -> `yuv420_10b_odd_even_convrn_enable` reads 0, 1, 0 on the respective lines.
  - A new `sensor_frame_start` -> next line reads 0.
- **Data delay:** pixels 0x3FF, 0x155, 0x2AA on consecutive cycles -> same values on `pixel_data` at +1 and on `pixel_data_d1` at +2.
- **Back-to-back lines** with a 1-cycle valid gap -> one falling-edge pulse. Second line starts at `pixel_cnt` 0 and odd/even toggles.
- **Line length check** (macro on): `cfg_line_length` = 16.
  - 16-pixel line -> `line_length_err` = 0.
  - 15-pixel line -> `line_length_err` = 1 and stays 1 until `sensor_frame_start`.

Source files
------------

// File: rtl/csi2tx_pixel_capture_pkg.sv
// Shared constants and pixel-bus layout for the CSI-2 TX pixel capture stages.
package csi2tx_pixel_capture_pkg;

    // Data-type width and the CSI-2 data types the capture stages care about.
    localparam int unsigned DT_W = 6;
    localparam logic [DT_W-1:0] DT_YUV420_8B  = 6'h18;
    localparam logic [DT_W-1:0] DT_YUV420_10B = 6'h19;
    localparam logic [DT_W-1:0] DT_YUV422_8B  = 6'h1E;
    localparam logic [DT_W-1:0] DT_RAW8       = 6'h2A;
    localparam logic [DT_W-1:0] DT_RAW10      = 6'h2B;
    localparam logic [DT_W-1:0] DT_RAW12      = 6'h2C;

    // Pixel bus and counter widths.
    localparam int unsigned PIX_W  = 32;
    localparam int unsigned COMP_W = 10;
    localparam int unsigned PCNT_W = 4;

    // Sensor pixel word: three 10-bit components at [29:20], [19:10], [9:0].
    typedef struct packed {
        logic [1:0]        rsvd;
        logic [COMP_W-1:0] c2;
        logic [COMP_W-1:0] c1;
        logic [COMP_W-1:0] c0;
    } pixel_word_t;

endpackage

// File: rtl/csi2tx_line_edge_det.sv
// Registered line valid with one-cycle rise and fall pulses aligned to it.
// rise_next_c is the combinational look-ahead of rise_o (the pulse one cycle early).
module csi2tx_line_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_next_c
);

    logic vld_q,  vld_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state: pulses mark the first cycle of a change on the registered valid.
    always_comb begin
        vld_d  = vld_i;
        rise_d = vld_i & ~vld_q;
        fall_d = vld_q & ~vld_i;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign vld_o       = vld_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign rise_next_c = rise_d;

endmodule

// File: rtl/csi2tx_pixel_capture.sv
// CSI-2 TX pixel capture: registers the sensor pixel bus and builds the timing
// companions (delayed data, pixel count, end-of-line pulse, YUV420 10-bit
// enables) for the pixel-to-byte converters.
// Optional feature: CSI2TX_LINE_LEN_CHECK_EN adds a sticky line length check.
module csi2tx_pixel_capture
    import csi2tx_pixel_capture_pkg::*;
#(
    parameter logic [5:0]  YUV420_10B_DT = DT_YUV420_10B,
    parameter int unsigned LINE_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sensor_frame_start,
    input  logic                  sensor_pixel_vld,
    input  logic [PIX_W-1:0]      sensor_pixel_data,
    input  logic [DT_W-1:0]       sensor_data_type,
    input  logic [LINE_CNT_W-1:0] cfg_line_length,
    output logic [PIX_W-1:0]      pixel_data,
    output logic [PIX_W-1:0]      pixel_data_d1,
    output logic                  pixel_data_vld,
    output logic [PCNT_W-1:0]     pixel_cnt,
    output logic                  sensor_pixel_vld_falling_edge,
    output logic                  yuv420_10b_convrn_enable,
    output logic                  yuv420_10b_odd_even_convrn_enable
`ifdef CSI2TX_LINE_LEN_CHECK_EN
    ,
    output logic                  line_length_err
`endif
);

    logic line_vld;
    logic line_start;
    logic line_fall;
    logic line_start_next;

    pixel_word_t         pix_q,      pix_d;
    pixel_word_t         pix_d1_q,   pix_d1_d;
    logic [PCNT_W-1:0]   pcnt_q,     pcnt_d;
    logic [DT_W-1:0]     dt_q,       dt_d;
    logic                yuv_en_q,   yuv_en_d;
    logic                odd_even_q, odd_even_d;

    // Valid register and line boundary pulses.
    csi2tx_line_edge_det u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_i       (sensor_pixel_vld),
        .vld_o       (line_vld),
        .rise_o      (line_start),
        .fall_o      (line_fall),
        .rise_next_c (line_start_next)
    );

    // Next-state for data pipe, pixel counter, line type and odd/even flag.
    always_comb begin
        pix_d      = sensor_pixel_data;
        pix_d1_d   = pix_q;
        pcnt_d     = pcnt_q;
        dt_d       = dt_q;
        odd_even_d = odd_even_q;

        // Count while the line continues, hold into the fall cycle, then clear.
        if (line_fall) begin
            pcnt_d = '0;
        end else if (line_vld) begin
            if (sensor_pixel_vld) begin
                pcnt_d = pcnt_q + PCNT_W'(1);
            end
        end else begin
            pcnt_d = '0;
        end

        // Type is taken with the first pixel so the enable is valid on it.
        if (line_start_next) begin
            dt_d = sensor_data_type;
        end
        yuv_en_d = (dt_d == YUV420_10B_DT);

        // Frame start wins over the end-of-line toggle.
        if (sensor_frame_start) begin
            odd_even_d = 1'b0;
        end else if (line_fall && yuv_en_q) begin
            odd_even_d = ~odd_even_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q      <= '0;
            pix_d1_q   <= '0;
            pcnt_q     <= '0;
            dt_q       <= '0;
            yuv_en_q   <= 1'b0;
            odd_even_q <= 1'b0;
        end else begin
            pix_q      <= pix_d;
            pix_d1_q   <= pix_d1_d;
            pcnt_q     <= pcnt_d;
            dt_q       <= dt_d;
            yuv_en_q   <= yuv_en_d;
            odd_even_q <= odd_even_d;
        end
    end

    assign pixel_data                        = pix_q;
    assign pixel_data_d1                     = pix_d1_q;
    assign pixel_data_vld                    = line_vld;
    assign pixel_cnt                         = pcnt_q;
    assign sensor_pixel_vld_falling_edge     = line_fall;
    assign yuv420_10b_convrn_enable          = yuv_en_q;
    assign yuv420_10b_odd_even_convrn_enable = odd_even_q;

`ifdef CSI2TX_LINE_LEN_CHECK_EN
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  len_err_q,  len_err_d;

    // Saturating count of valid cycles in the line; compared on the fall pulse.
    always_comb begin
        line_cnt_d = line_cnt_q;
        len_err_d  = len_err_q;

        if (line_start) begin
            line_cnt_d = LINE_CNT_W'(1);
        end else if (line_vld && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
        end

        if (sensor_frame_start) begin
            len_err_d = 1'b0;
        end else if (line_fall && (line_cnt_q != cfg_line_length)) begin
            len_err_d = 1'b1;
        end
    end

    // Line length check registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            line_cnt_q <= line_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign line_length_err = len_err_q;
`else
    logic unused_len_chk;
    assign unused_len_chk = ^{cfg_line_length, line_start};
`endif

endmodule

// File: tb/tb_csi2tx_pixel_capture.sv
// Self-checking bench for csi2tx_pixel_capture: directed scenarios with literal
// expectations plus a randomized run against a line-level behavioural model.
module tb_csi2tx_pixel_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_fs;
    logic        s_vld;
    logic [31:0] s_data;
    logic [5:0]  s_dt;
    logic [15:0] s_cfg;

    logic [31:0] pixel_data;
    logic [31:0] pixel_data_d1;
    logic        pixel_data_vld;
    logic [3:0]  pixel_cnt;
    logic        fall_pulse;
    logic        yuv_en;
    logic        odd_even;
`ifdef CSI2TX_LINE_LEN_CHECK_EN
    logic        len_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csi2tx_pixel_capture dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .sensor_frame_start                (s_fs),
        .sensor_pixel_vld                  (s_vld),
        .sensor_pixel_data                 (s_data),
        .sensor_data_type                  (s_dt),
        .cfg_line_length                   (s_cfg),
        .pixel_data                        (pixel_data),
        .pixel_data_d1                     (pixel_data_d1),
        .pixel_data_vld                    (pixel_data_vld),
        .pixel_cnt                         (pixel_cnt),
        .sensor_pixel_vld_falling_edge     (fall_pulse),
        .yuv420_10b_convrn_enable          (yuv_en),
        .yuv420_10b_odd_even_convrn_enable (odd_even)
`ifdef CSI2TX_LINE_LEN_CHECK_EN
        ,
        .line_length_err                   (len_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (line level) ----------------
    logic [31:0] m_data, m_d1;
    logic        m_vld, m_fall, m_en, m_oe, m_err;
    int          m_cnt;
    int          pix_idx;      // index of current pixel in the line
    int          line_len;     // pixels seen in current line (saturating)
    int          yuv_done;     // YUV420-10b lines completed since frame start

    task automatic model_reset();
        m_data = '0; m_d1 = '0; m_vld = 1'b0; m_fall = 1'b0; m_en = 1'b0;
        m_oe = 1'b0; m_err = 1'b0; m_cnt = 0; pix_idx = 0; line_len = 0; yuv_done = 0;
    endtask

    task automatic model_step();
        logic was_fall, prev_vld, old_en;
        int   old_len;
        was_fall = m_fall;
        prev_vld = m_vld;
        old_en   = m_en;
        old_len  = line_len;
        // completed line bookkeeping (effects show the cycle after the pulse)
        if (s_fs) begin
            yuv_done = 0;
            m_err    = 1'b0;
        end else if (was_fall) begin
            if (old_en) yuv_done++;
            if (old_len != int'(s_cfg)) m_err = 1'b1;
        end
        m_d1   = m_data;
        m_data = s_data;
        m_vld  = s_vld;
        m_fall = prev_vld && !s_vld;
        if (s_vld && !prev_vld) begin
            pix_idx  = 0;
            line_len = 1;
            m_en     = (s_dt == 6'h19);
        end else if (s_vld) begin
            pix_idx++;
            if (line_len < 65535) line_len++;
        end
        if (s_vld)        m_cnt = pix_idx % 16;
        else if (!m_fall) m_cnt = 0;
        m_oe = yuv_done[0];
    endtask

    // Compare process: model advances on every rising edge, DUT checked on falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset(); else model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("pixel_data",    pixel_data,           m_data);
            chk("pixel_data_d1", pixel_data_d1,        m_d1);
            chk("pixel_vld",     32'(pixel_data_vld),  32'(m_vld));
            chk("pixel_cnt",     32'(pixel_cnt),       32'(m_cnt));
            chk("fall_pulse",    32'(fall_pulse),      32'(m_fall));
            chk("yuv_en",        32'(yuv_en),          32'(m_en));
            chk("odd_even",      32'(odd_even),        32'(m_oe));
`ifdef CSI2TX_LINE_LEN_CHECK_EN
            chk("len_err",       32'(len_err),         32'(m_err));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_vld = 1'b0; s_fs = 1'b0; s_data = $urandom; s_dt = 6'($urandom);
            tick();
        end
    endtask

    task automatic frame_start();
        s_vld = 1'b0; s_fs = 1'b1; s_data = $urandom;
        tick();
        s_fs = 1'b0;
    endtask

    // One line of n pixels (type only valid on the first), then gap idle cycles.
    task automatic send_line(input int n, input logic [5:0] t, input int gap,
                             output logic en_first, output logic oe_first,
                             output logic [3:0] cnt_first, output logic fall_first);
        en_first = 1'b0; oe_first = 1'b0; cnt_first = '0; fall_first = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_vld  = 1'b1;
            s_data = $urandom;
            s_dt   = (i == 0) ? t : 6'($urandom);
            tick();
            if (i == 0) begin
                en_first = yuv_en; oe_first = odd_even;
                cnt_first = pixel_cnt; fall_first = fall_pulse;
            end
        end
        for (int g = 0; g < gap; g++) begin
            s_vld = 1'b0; s_data = $urandom; s_dt = 6'($urandom);
            tick();
        end
    endtask

    initial begin
        logic       en1, oe1, fl1;
        logic [3:0] c1;
        int         remaining, gap;
        logic [5:0] ltype;
        logic       first;

        rst_n = 1'b1; s_fs = 1'b0; s_vld = 1'b0; s_data = '0; s_dt = '0; s_cfg = 16'd16;
        #2 rst_n = 1'b0;

        // Reset with random inputs: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            s_fs = 1'($urandom); s_vld = 1'($urandom); s_data = $urandom; s_dt = 6'($urandom);
            tick();
            chk("rst_pixel_data", pixel_data, 32'h0);
            chk("rst_vld",        32'(pixel_data_vld), 32'h0);
            chk("rst_odd_even",   32'(odd_even), 32'h0);
        end
        s_fs = 1'b0; s_vld = 1'b0; s_data = '0; s_dt = '0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_data", pixel_data, 32'h0);
        chk("post_rst_cnt",  32'(pixel_cnt), 32'h0);
        chk("post_rst_fall", 32'(fall_pulse), 32'h0);
        chk("post_rst_en",   32'(yuv_en), 32'h0);

        // 20-pixel RAW10 line: count 0..15, 0..3, then pulse with count held at 3.
        for (int i = 0; i < 20; i++) begin
            s_vld = 1'b1; s_data = $urandom; s_dt = (i == 0) ? 6'h2B : 6'h19;
            tick();
            chk("raw_cnt", 32'(pixel_cnt), 32'(i % 16));
            chk("raw_en",  32'(yuv_en), 32'h0);
        end
        s_vld = 1'b0;
        tick();
        chk("raw_fall",     32'(fall_pulse), 32'h1);
        chk("raw_fall_cnt", 32'(pixel_cnt), 32'h3);
        chk("raw_fall_vld", 32'(pixel_data_vld), 32'h0);
        tick();
        chk("raw_clr_cnt",  32'(pixel_cnt), 32'h0);
        chk("raw_clr_fall", 32'(fall_pulse), 32'h0);

        // Data delay: +1 on pixel_data, +2 on pixel_data_d1.
        s_data = 32'h3FF; tick();
        chk("dly0_pd", pixel_data, 32'h3FF);
        s_data = 32'h155; tick();
        chk("dly1_pd", pixel_data, 32'h155);
        chk("dly1_d1", pixel_data_d1, 32'h3FF);
        s_data = 32'h2AA; tick();
        chk("dly2_pd", pixel_data, 32'h2AA);
        chk("dly2_d1", pixel_data_d1, 32'h155);
        s_data = 32'h0; tick();
        chk("dly3_d1", pixel_data_d1, 32'h2AA);

        // YUV420 10-bit frame of 3 lines: odd/even 0,1,0; new frame restarts at 0.
        frame_start(); idle(1);
        send_line(8, 6'h19, 3, en1, oe1, c1, fl1);
        chk("yuv_l0_en", 32'(en1), 32'h1);
        chk("yuv_l0_oe", 32'(oe1), 32'h0);
        send_line(8, 6'h19, 3, en1, oe1, c1, fl1);
        chk("yuv_l1_oe", 32'(oe1), 32'h1);
        send_line(8, 6'h19, 3, en1, oe1, c1, fl1);
        chk("yuv_l2_oe", 32'(oe1), 32'h0);
        frame_start(); idle(1);
        send_line(8, 6'h19, 3, en1, oe1, c1, fl1);
        chk("yuv_f2_oe", 32'(oe1), 32'h0);

        // Back-to-back lines with a one-cycle gap.
        send_line(18, 6'h19, 1, en1, oe1, c1, fl1);
        chk("b2b_l0_oe",   32'(oe1), 32'h1);
        chk("b2b_fall",    32'(fall_pulse), 32'h1);
        chk("b2b_fall_cnt", 32'(pixel_cnt), 32'h1);
        send_line(5, 6'h19, 3, en1, oe1, c1, fl1);
        chk("b2b_l1_cnt",  32'(c1), 32'h0);
        chk("b2b_l1_fall", 32'(fl1), 32'h0);
        chk("b2b_l1_oe",   32'(oe1), 32'h0);

`ifdef CSI2TX_LINE_LEN_CHECK_EN
        // Line length check against 16 pixels; sticky until frame start.
        s_cfg = 16'd16;
        frame_start(); idle(1);
        send_line(16, 6'h2B, 2, en1, oe1, c1, fl1);
        chk("len16_err", 32'(len_err), 32'h0);
        send_line(15, 6'h2B, 2, en1, oe1, c1, fl1);
        chk("len15_err", 32'(len_err), 32'h1);
        send_line(16, 6'h2B, 2, en1, oe1, c1, fl1);
        chk("len_sticky", 32'(len_err), 32'h1);
        frame_start();
        chk("len_fs_clr", 32'(len_err), 32'h0);
`endif

        // Randomized traffic: lines of random length/type, frame starts, rare resets.
        remaining = 0; gap = 0; ltype = 6'h19; first = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (remaining == 0 && gap == 0) begin
                remaining = $urandom_range(1, 40);
                gap       = $urandom_range(1, 4);
                case ($urandom_range(0, 2))
                    0:       ltype = 6'h19;
                    1:       ltype = 6'h2B;
                    default: ltype = 6'($urandom);
                endcase
                s_cfg = ($urandom_range(0, 2) == 0) ? 16'(remaining) : 16'd16;
                first = 1'b1;
            end
            if (remaining > 0) begin
                s_vld = 1'b1;
                s_dt  = first ? ltype : 6'($urandom);
                first = 1'b0;
                remaining--;
            end else begin
                s_vld = 1'b0;
                s_dt  = 6'($urandom);
                gap--;
            end
            s_data = $urandom;
            s_fs   = ($urandom_range(0, 29) == 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
